// File: rtl/alu_exec_ctrl.sv
// Execute-stage controller driving a combinational ALU and owning the accumulator.
// Retires one instruction per 3 cycles (accept N -> done in N+2); instr_ready low while busy.
module alu_exec_ctrl #(
  parameter int DATA_W     = 16,
  parameter int OP_W       = 4,
  parameter bit STICKY_OVF = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [OP_W-1:0]   instr_op,
  input  logic [DATA_W-1:0] instr_opnd,
  input  logic              ovf_clr,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_op,
  input  logic [DATA_W:0]   alu_res,
  input  logic [1:0]        alu_flag,
  output logic [DATA_W-1:0] acc,
  output logic              zero_flag,
  output logic              ovf_flag,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

  localparam logic [OP_W-1:0] OP_LDI = OP_W'(8);

  state_t            state;
  logic [OP_W-1:0]   op_q;
  logic [DATA_W-1:0] opnd_q;
  logic              accept;
  logic              is_alu;
  logic              is_ldi;
  logic              ovf_keep;
  logic              ovf_alu;
  logic              unused_res_msb;

  assign instr_ready = (state == S_IDLE);
  assign accept      = instr_valid & instr_ready;
  assign is_alu      = (op_q < OP_LDI);
  assign is_ldi      = (op_q == OP_LDI);

  // Overflow comes from the ALU flag port; the result MSB carries the same information.
  assign unused_res_msb = alu_res[DATA_W];

  // Sticky mode: a clear drops the old value, but a same-cycle ALU overflow still sets it.
  assign ovf_keep = STICKY_OVF ? (ovf_flag & ~ovf_clr) : ovf_flag;
  assign ovf_alu  = STICKY_OVF ? (ovf_keep | alu_flag[1]) : alu_flag[1];

  assign alu_a  = acc;
  assign alu_b  = opnd_q;
  assign alu_op = op_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      op_q      <= '0;
      opnd_q    <= '0;
      acc       <= '0;
      zero_flag <= 1'b0;
      ovf_flag  <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done     <= 1'b0;
      err      <= 1'b0;
      ovf_flag <= ovf_keep;
      case (state)
        S_IDLE: begin
          if (accept) begin
            op_q   <= instr_op;
            opnd_q <= instr_opnd;
            state  <= S_EXEC;
          end
        end
        S_EXEC: begin
          done <= 1'b1;
          if (is_alu) begin
            acc       <= alu_res[DATA_W-1:0];
            zero_flag <= alu_flag[0];
            ovf_flag  <= ovf_alu;
          end else if (is_ldi) begin
            acc       <= opnd_q;
            zero_flag <= (opnd_q == '0);
          end else if (op_q != OP_W'(9)) begin
            err <= 1'b1;
          end
          state <= S_DONE;
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Randomized bench for alu_exec_ctrl with a behavioural ALU and accumulator reference model.
module tb_alu_exec_ctrl;

  localparam bit STICKY = 1'b1;

  logic        clk;
  logic        rst_n;
  logic        instr_valid;
  logic        instr_ready;
  logic [3:0]  instr_op;
  logic [15:0] instr_opnd;
  logic        ovf_clr;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [3:0]  alu_op;
  logic [16:0] alu_res;
  logic [1:0]  alu_flag;
  logic [15:0] acc;
  logic        zero_flag;
  logic        ovf_flag;
  logic        done;
  logic        err;

  int total;
  int bad;

  logic [15:0] m_acc;
  logic        m_z;
  logic        m_o;

  alu_exec_ctrl #(.DATA_W(16), .OP_W(4), .STICKY_OVF(STICKY)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr_op    (instr_op),
    .instr_opnd  (instr_opnd),
    .ovf_clr     (ovf_clr),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_op      (alu_op),
    .alu_res     (alu_res),
    .alu_flag    (alu_flag),
    .acc         (acc),
    .zero_flag   (zero_flag),
    .ovf_flag    (ovf_flag),
    .done        (done),
    .err         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [16:0] alu_f(input logic [15:0] a, input logic [15:0] b,
                                        input logic [3:0] op);
    case (op)
      4'd0:    alu_f = {1'b0, a} + {1'b0, b};
      4'd1:    alu_f = {1'b0, a} - {1'b0, b};
      4'd2:    alu_f = {1'b0, a} + 17'd1;
      4'd3:    alu_f = {1'b0, a} - 17'd1;
      4'd4:    alu_f = {1'b0, a & b};
      4'd5:    alu_f = {1'b0, a | b};
      4'd6:    alu_f = {1'b0, a ^ b};
      4'd7:    alu_f = {1'b0, ~a};
      default: alu_f = 17'd0;
    endcase
  endfunction

  always_comb begin
    alu_res  = alu_f(alu_a, alu_b, alu_op);
    alu_flag = {alu_res[16], alu_res[15:0] == 16'h0000};
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Reference: what one retired instruction does to acc/flags.
  task automatic model_step(input logic [3:0] op, input logic [15:0] opnd, input logic clr,
                            output logic e);
    logic [16:0] r;
    e = 1'b0;
    if (op < 4'd8) begin
      r     = alu_f(m_acc, opnd, op);
      m_acc = r[15:0];
      m_z   = (r[15:0] == 16'h0000);
      m_o   = STICKY ? ((m_o & ~clr) | r[16]) : r[16];
    end else begin
      if (STICKY) m_o = m_o & ~clr;
      if (op == 4'd8) begin
        m_acc = opnd;
        m_z   = (opnd == 16'h0000);
      end else if (op != 4'd9) begin
        e = 1'b1;
      end
    end
  endtask

  // Entered and left at a negedge with the controller idle.
  task automatic run_instr(input logic [3:0] op, input logic [15:0] opnd, input logic clr);
    logic e;
    check_eq("ready_idle", instr_ready, 1);
    instr_valid = 1'b1;
    instr_op    = op;
    instr_opnd  = opnd;
    @(negedge clk);
    instr_valid = 1'b0;
    instr_op    = 4'($urandom);
    instr_opnd  = 16'($urandom);
    ovf_clr     = clr;
    check_eq("ready_exec", instr_ready, 0);
    check_eq("done_exec", done, 0);
    check_eq("alu_a", alu_a, m_acc);
    check_eq("alu_b", alu_b, opnd);
    check_eq("alu_op", alu_op, op);
    model_step(op, opnd, clr, e);
    @(negedge clk);
    ovf_clr = 1'b0;
    check_eq("done_pulse", done, 1);
    check_eq("err", err, e);
    check_eq("acc", acc, m_acc);
    check_eq("zero_flag", zero_flag, m_z);
    check_eq("ovf_flag", ovf_flag, m_o);
    check_eq("ready_done", instr_ready, 0);
    @(negedge clk);
    check_eq("done_clear", done, 0);
    check_eq("ready_back", instr_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic e;
    logic [3:0]  rop;
    logic [15:0] ropnd;
    total = 0;
    bad   = 0;
    m_acc = 16'h0;
    m_z   = 1'b0;
    m_o   = 1'b0;
    rst_n       = 1'b0;
    instr_valid = 1'b0;
    instr_op    = 4'd0;
    instr_opnd  = 16'h0;
    ovf_clr     = 1'b0;

    repeat (2) @(negedge clk);
    check_eq("rst_ready", instr_ready, 1);
    check_eq("rst_acc", acc, 0);
    check_eq("rst_zero", zero_flag, 0);
    check_eq("rst_ovf", ovf_flag, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_err", err, 0);
    check_eq("rst_alu_b", alu_b, 0);
    check_eq("rst_alu_op", alu_op, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed cases
    run_instr(4'd8, 16'h0005, 1'b0);
    run_instr(4'd0, 16'h0003, 1'b0);
    check_eq("t1_acc", acc, 16'h0008);
    check_eq("t1_zero", zero_flag, 0);

    run_instr(4'd8, 16'h0004, 1'b0);
    run_instr(4'd1, 16'h0004, 1'b0);
    check_eq("t2_acc", acc, 16'h0000);
    check_eq("t2_zero", zero_flag, 1);

    run_instr(4'd8, 16'hFFFF, 1'b0);
    run_instr(4'd2, 16'h0000, 1'b0);
    check_eq("t3_acc", acc, 16'h0000);
    check_eq("t3_zero", zero_flag, 1);
    check_eq("t3_ovf", ovf_flag, 1);

    // Idle clear of the sticky overflow
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    m_o = 1'b0;
    check_eq("idle_clr_ovf", ovf_flag, 0);

    run_instr(4'd8, 16'h1234, 1'b0);
    run_instr(4'd12, 16'h5555, 1'b0);
    check_eq("t4_acc", acc, 16'h1234);

    // Back-to-back with valid held high and opnd churning every cycle
    instr_valid = 1'b1;
    instr_op    = 4'd2;
    for (int k = 0; k < 9; k++) begin
      check_eq("hold_ready", instr_ready, (k % 3) == 0);
      check_eq("hold_done", done, (k % 3) == 2);
      if ((k % 3) == 0) model_step(4'd2, 16'h0, 1'b0, e);
      @(negedge clk);
      instr_opnd = 16'($urandom);
    end
    instr_valid = 1'b0;
    check_eq("hold_acc", acc, m_acc);
    check_eq("hold_acc_abs", acc, 16'h1237);
    check_eq("hold_ready_end", instr_ready, 1);

    // Mid-instruction reset aborts
    run_instr(4'd8, 16'h1111, 1'b0);
    instr_valid = 1'b1;
    instr_op    = 4'd0;
    instr_opnd  = 16'h0007;
    @(negedge clk);
    instr_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    m_acc = 16'h0;
    m_z   = 1'b0;
    m_o   = 1'b0;
    check_eq("t6_acc", acc, 0);
    check_eq("t6_zero", zero_flag, 0);
    check_eq("t6_ovf", ovf_flag, 0);
    check_eq("t6_ready", instr_ready, 1);
    check_eq("t6_done", done, 0);
    @(negedge clk);
    check_eq("t6_done_rst", done, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("t6_done_after", done, 0);
    check_eq("t6_ready_after", instr_ready, 1);

    // Randomized instruction stream
    for (int i = 0; i < 80; i++) begin
      rop   = 4'($urandom_range(0, 15));
      ropnd = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 3)) : 16'($urandom);
      run_instr(rop, ropnd, $urandom_range(0, 3) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
